// File: rtl/collatz_pkg.sv
// Collatz engine shared types: FSM state encoding and
// default widths for the starting value, working value and step counter.
package collatz_pkg;

    localparam int IN_W_DEF   = 16;
    localparam int WORK_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: even -> cur/2, odd -> 3*cur+1.
// Ports: cur (in), nxt (truncated next value), ovf (next value exceeds WORK_W).
module collatz_step
    import collatz_pkg::*;
#(
    parameter int WORK_W = WORK_W_DEF
) (
    input  logic [WORK_W-1:0] cur,
    output logic [WORK_W-1:0] nxt,
    output logic              ovf
);

    localparam int XW = WORK_W + 2;

    logic [XW-1:0] ext;
    logic [XW-1:0] wide;

    // Two guard bits hold the worst case 3*(2^W-1)+1 exactly.
    always_comb begin
        ext = {2'b00, cur};
        if (cur[0]) begin
            wide = (ext << 1) + ext + XW'(1);
        end else begin
            wide = ext >> 1;
        end
        nxt = wide[WORK_W-1:0];
        ovf = |wide[XW-1:WORK_W];
    end

endmodule

// File: rtl/collatz_engine.sv
// Iterative Collatz run engine: one step per clock until cur reaches 1.
// Ports: clk, rst (async high), start, n_in -> busy, done, err, steps, peak.
// Optional macro COLLATZ_PEAK_EN enables peak tracking; otherwise peak is 0.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int WORK_W = WORK_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   n_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  steps,
    output logic [WORK_W-1:0] peak
);

    state_t            state_q, state_d;
    logic [WORK_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  steps_q, steps_d;
    logic              err_q, err_d;

    logic [WORK_W-1:0] nxt;
    logic              ovf;
    logic [WORK_W-1:0] n_ext;
    logic              is_zero;
    logic              is_one;
    logic              sat;
    logic              accept;
    logic              do_step;

    collatz_step #(
        .WORK_W (WORK_W)
    ) u_step (
        .cur (cur_q),
        .nxt (nxt),
        .ovf (ovf)
    );

    assign n_ext   = WORK_W'(n_in);
    assign is_zero = (cur_q == '0);
    assign is_one  = (cur_q == WORK_W'(1));
    assign sat     = (steps_q == {CNT_W{1'b1}});
    assign accept  = (state_q == IDLE) && start;
    // A real step only when nothing terminates the run this edge.
    assign do_step = (state_q == RUN) && !is_zero && !is_one
                     && !sat && !ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) state_d = RUN;
            end
            (state_q == RUN): begin
                if (!do_step) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d   = cur_q;
        steps_d = steps_q;
        err_d   = err_q;
        if (accept) begin
            cur_d   = n_ext;
            steps_d = '0;
            err_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (is_zero) begin
                err_d   = 1'b1;
                steps_d = '0;
            end else if (is_one) begin
                err_d = 1'b0;
            end else if (sat || ovf) begin
                // Abort leaves cur/steps/peak as they were.
                err_d = 1'b1;
            end else begin
                cur_d   = nxt;
                steps_d = steps_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        err   = err_q;
        steps = steps_q;
    end

`ifdef COLLATZ_PEAK_EN
    logic [WORK_W-1:0] peak_q, peak_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    always_comb begin
        peak_d = peak_q;
        if (accept) begin
            peak_d = n_ext;
        end else if (do_step && (nxt > peak_q)) begin
            peak_d = nxt;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine: default, WORK_W=16 and CNT_W=4 builds.
// Expected values are hand-computed Collatz trajectories.
module tb_collatz_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_in;
    int          sel;

    logic        busy_a, done_a, err_a;
    logic [15:0] steps_a;
    logic [31:0] peak_a;
    logic        busy_b, done_b, err_b;
    logic [15:0] steps_b;
    logic [15:0] peak_b;
    logic        busy_c, done_c, err_c;
    logic [3:0]  steps_c;
    logic [31:0] peak_c;

    logic        start_a, start_b, start_c;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    collatz_engine u_a (
        .clk (clk), .rst (rst), .start (start_a), .n_in (n_in),
        .busy (busy_a), .done (done_a), .err (err_a),
        .steps (steps_a), .peak (peak_a)
    );

    collatz_engine #(.IN_W(16), .WORK_W(16), .CNT_W(16)) u_b (
        .clk (clk), .rst (rst), .start (start_b), .n_in (n_in),
        .busy (busy_b), .done (done_b), .err (err_b),
        .steps (steps_b), .peak (peak_b)
    );

    collatz_engine #(.IN_W(16), .WORK_W(32), .CNT_W(4)) u_c (
        .clk (clk), .rst (rst), .start (start_c), .n_in (n_in),
        .busy (busy_c), .done (done_c), .err (err_c),
        .steps (steps_c), .peak (peak_c)
    );

    always #5 clk = ~clk;

    logic        done_s, busy_s, err_s;
    logic [31:0] steps_s, peak_s;

    always_comb begin
        done_s  = done_a;
        busy_s  = busy_a;
        err_s   = err_a;
        steps_s = 32'(steps_a);
        peak_s  = peak_a;
        if (sel == 1) begin
            done_s  = done_b;
            busy_s  = busy_b;
            err_s   = err_b;
            steps_s = 32'(steps_b);
            peak_s  = 32'(peak_b);
        end else if (sel == 2) begin
            done_s  = done_c;
            busy_s  = busy_c;
            err_s   = err_c;
            steps_s = 32'(steps_c);
            peak_s  = peak_c;
        end
    end

    int checks = 0;
    int errors = 0;

    int          lat;
    logic [31:0] r_steps, r_peak;
    logic        r_err;
    logic        r_busy_run;
    logic        r_busy_idle;

    function automatic logic [31:0] pk(input logic [31:0] v);
`ifdef COLLATZ_PEAK_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int s, input logic [15:0] n);
        sel   = s;
        n_in  = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        r_busy_run = busy_s;
    endtask

    task automatic wait_done(input int base);
        lat = -1;
        for (int c = base; c <= base + 400; c++) begin
            @(negedge clk);
            if (done_s) begin
                lat = c;
                break;
            end
        end
        r_steps = steps_s;
        r_peak  = peak_s;
        r_err   = err_s;
        @(negedge clk);
        r_busy_idle = busy_s;
    endtask

    task automatic run(input int s, input logic [15:0] n);
        launch(s, n);
        wait_done(1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n_in  = '0;
        sel   = 0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {29'd0, busy_a, done_a, err_a}, 32'd0);
        chk("rst_steps", 32'(steps_a), 32'd0);
        chk("rst_peak", peak_a, 32'd0);
        rst = 1'b0;

        run(0, 16'd27);
        chk("n27_busy", {31'd0, r_busy_run}, 32'd1);
        chk("n27_lat", 32'(lat), 32'd113);
        chk("n27_steps", r_steps, 32'd111);
        chk("n27_peak", r_peak, pk(32'd9232));
        chk("n27_err", {31'd0, r_err}, 32'd0);
        chk("n27_idle", {31'd0, r_busy_idle}, 32'd0);

        run(0, 16'd6);
        chk("n6_lat", 32'(lat), 32'd10);
        chk("n6_steps", r_steps, 32'd8);
        chk("n6_peak", r_peak, pk(32'd16));
        chk("n6_err", {31'd0, r_err}, 32'd0);

        run(0, 16'd1);
        chk("n1_lat", 32'(lat), 32'd2);
        chk("n1_steps", r_steps, 32'd0);
        chk("n1_peak", r_peak, pk(32'd1));
        chk("n1_err", {31'd0, r_err}, 32'd0);

        run(0, 16'd0);
        chk("n0_lat", 32'(lat), 32'd2);
        chk("n0_err", {31'd0, r_err}, 32'd1);
        chk("n0_steps", r_steps, 32'd0);
        repeat (3) @(negedge clk);
        chk("n0_err_held", {31'd0, err_a}, 32'd1);

        run(1, 16'd65535);
        chk("w16_lat", 32'(lat), 32'd2);
        chk("w16_err", {31'd0, r_err}, 32'd1);
        chk("w16_steps", r_steps, 32'd0);
        chk("w16_peak", r_peak, pk(32'd65535));

        run(2, 16'd27);
        chk("c4_lat", 32'(lat), 32'd17);
        chk("c4_err", {31'd0, r_err}, 32'd1);
        chk("c4_steps", r_steps, 32'd15);
        chk("c4_peak", r_peak, pk(32'd484));

        launch(0, 16'd27);
        repeat (5) @(negedge clk);
        n_in  = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(7);
        chk("ign_lat", 32'(lat), 32'd113);
        chk("ign_steps", r_steps, 32'd111);
        chk("ign_peak", r_peak, pk(32'd9232));

        launch(0, 16'd27);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_done", {31'd0, done_a}, 32'd0);
        chk("mid_err", {31'd0, err_a}, 32'd0);
        chk("mid_steps", 32'(steps_a), 32'd0);
        chk("mid_peak", peak_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(0, 16'd6);
        chk("post_lat", 32'(lat), 32'd10);
        chk("post_steps", r_steps, 32'd8);
        chk("post_peak", r_peak, pk(32'd16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/collatz_engine.md
COLLATZ_ENGINE -- requirements
Module: collatz_engine

Interface
REQ-001 SHALL have parameter IN_W, default 16, width of the starting value.
REQ-002 SHALL have parameter WORK_W, default 32, width of the working value register (WORK_W >= IN_W).
REQ-003 SHALL have parameter CNT_W, default 16, width of the step counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, request to begin a run; sampled only in IDLE.
REQ-007 SHALL have port n_in, input, IN_W, starting value; captured on the accepted start edge.
REQ-008 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking run completion.
REQ-010 SHALL have port err, output, 1, run ended abnormally; valid with done, held until the next accepted start.
REQ-011 SHALL have port steps, output, CNT_W, step count of the last run; held until the next accepted start.
REQ-012 SHALL have port peak, output, WORK_W, maximum working value of the last run; held until the next accepted start.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL transition to RUN and load cur=zero-extended n_in, steps=0, peak=n_in, err=0 (edge k).
REQ-015 Each RUN edge with cur>1 SHALL perform exactly one step (even: cur>>1; odd: 3*cur+1), increment steps and set peak=max(peak, new cur).
REQ-016 A RUN edge with cur==1 SHALL transition to DONE with err=0; done is therefore high for the cycle after edge k+1+S, where S is the step count.
REQ-017 A RUN edge with cur==0 SHALL transition to DONE with err=1 and steps=0.
REQ-018 If an odd step's 3*cur+1 exceeds 2^WORK_W-1, that edge SHALL transition to DONE with err=1, leaving cur, steps and peak unchanged.
REQ-019 If a step is required while steps==2^CNT_W-1, that edge SHALL transition to DONE with err=1 and steps held at the saturated value.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 busy SHALL be low in IDLE, so a new start is accepted on the first edge after done.
REQ-023 Arithmetic SHALL be performed at WORK_W+2 bits internally so overflow is detected exactly.

Reset
REQ-024 Assertion of rst SHALL immediately force state=IDLE, busy=0, done=0, err=0, steps=0, peak=0 and cur=0, including mid-run.
REQ-025 The first start SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-026 With macro COLLATZ_PEAK_EN defined, peak tracking SHALL behave per REQ-012, REQ-014 and REQ-015.
REQ-027 Without COLLATZ_PEAK_EN, peak SHALL be constant 0, no peak register or comparator SHALL be synthesized, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package collatz_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default values of IN_W, WORK_W and CNT_W.
REQ-029 The block SHALL use one combinational sub-module, collatz_step (cur -> next value, overflow flag), instantiated once.

Verification
REQ-030 n_in=27 -> done 113 cycles after the start edge, steps=111, peak=9232, err=0.
REQ-031 n_in=6 -> steps=8, peak=16, err=0; n_in=1 -> done 2 cycles after the start edge, steps=0, peak=1.
REQ-032 n_in=0 -> done 2 cycles after the start edge, err=1, steps=0.
REQ-033 WORK_W=16, n_in=65535 -> err=1 on the first step, steps=0, peak=65535.
REQ-034 CNT_W=4, n_in=27 -> err=1, steps=15.
REQ-035 start pulsed during RUN is ignored, and rst mid-run forces all outputs to 0; a subsequent n_in=6 run returns steps=8.
